// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall signal bundle between the pipeline stages and the central stall controller.
// The controller side uses the slave modport; the pipeline (or a bench) uses master.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_stall_request;
    logic             ex_mdu_start;
    logic             ex_mdu_div;
    logic             mem_ram_req;
    logic             mem_ram_ready;
    logic [5:0]       stall;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    modport master (
        output id_stall_request, ex_mdu_start, ex_mdu_div, mem_ram_req, mem_ram_ready,
        input  stall, mdu_busy, mdu_done, stall_cycles, mem_timeout
    );

    modport slave (
        input  id_stall_request, ex_mdu_start, ex_mdu_div, mem_ram_req, mem_ram_ready,
        output stall, mdu_busy, mdu_done, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: merges load-use, MDU latency and RAM wait hazards into one
// per-stage stall vector, with a stalled-cycle counter and a sticky RAM timeout flag.
module pipe_stall_ctrl #(
    parameter int MUL_LAT     = 3,
    parameter int DIV_LAT     = 32,
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);
    localparam int          WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [5:0]  MUL_LOAD  = 6'(MUL_LAT - 1);
    localparam logic [5:0]  DIV_LOAD  = 6'(DIV_LAT - 1);

    typedef enum logic {S_RUN, S_MDU} state_t;

    state_t            state_reg, state_next;
    logic [5:0]        cnt_reg, cnt_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0]  stall_cycles_reg;
    logic              mem_timeout_reg;
    logic              mem_wait;
    logic              ex_hold;
    logic              mdu_done_next;

    assign mem_wait = bus.mem_ram_req & ~bus.mem_ram_ready;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ex_hold       = 1'b0;
        mdu_done_next = 1'b0;
        case (state_reg)
            S_RUN: begin
                // A start seen during a RAM wait is held in EX and retried next cycle.
                if (bus.ex_mdu_start) begin
                    ex_hold = 1'b1;
                    if (!mem_wait) begin
                        state_next = S_MDU;
                        cnt_next   = bus.ex_mdu_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
            end
            S_MDU: begin
                if (mem_wait) begin
                    ex_hold = 1'b1;
                end else if (cnt_reg != 6'd0) begin
                    ex_hold  = 1'b1;
                    cnt_next = cnt_reg - 6'd1;
                end else begin
                    mdu_done_next = 1'b1;
                    state_next    = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_RUN;
            cnt_reg   <= 6'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Each stage bit is asserted by every hazard whose reach covers that stage.
    for (genvar gi = 0; gi < 6; gi++) begin : g_stall
        assign bus.stall[gi] = ~rst & ((mem_wait         & (gi <= 4)) |
                                       (ex_hold          & (gi <= 3)) |
                                       (bus.id_stall_request & (gi <= 2)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (bus.stall[0] && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    // wait_cnt parks at its last value so a very long wait never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else if (mem_wait) begin
            if (wait_cnt_reg == WAIT_LAST) begin
                mem_timeout_reg <= 1'b1;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign bus.mdu_busy     = (state_reg == S_MDU);
    assign bus.mdu_done     = mdu_done_next & ~rst;
    assign bus.stall_cycles = stall_cycles_reg;
    assign bus.mem_timeout  = mem_timeout_reg;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scenarios followed by random traffic, all checked against a cycle model
// written from the stall priority, MDU latency and RAM timeout rules.
module tb_pipe_stall_ctrl;
    localparam int MUL_LAT     = 3;
    localparam int DIV_LAT     = 32;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(
        .MUL_LAT    (MUL_LAT),
        .DIV_LAT    (DIV_LAT),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    bit m_valid   = 0;   // registered outputs are defined once a reset edge has passed
    bit m_busy    = 0;   // an MDU op has been accepted and not yet completed
    int m_lat     = 0;   // latency of the op in flight
    int m_elapsed = 0;   // productive (non-wait) cycles the op has spent in EX so far
    int m_waitrun = 0;   // consecutive RAM-wait cycles seen
    bit m_timeout = 0;
    int m_scount  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cyc(input bit r, input bit i, input bit s, input bit d,
                       input bit q, input bit y);
        bit         w;
        bit         done_now;
        bit         hold;
        logic [5:0] exp_stall;
        @(posedge clk);
        #1;
        rst = r;
        bus.id_stall_request = i;
        bus.ex_mdu_start     = s;
        bus.ex_mdu_div       = d;
        bus.mem_ram_req      = q;
        bus.mem_ram_ready    = y;
        #3;
        w        = q && !y;
        done_now = !r && m_busy && !w && (m_elapsed == m_lat);
        hold     = (!m_busy && s) || (m_busy && !done_now);
        if (r)         exp_stall = 6'b000000;
        else if (w)    exp_stall = 6'b011111;
        else if (hold) exp_stall = 6'b001111;
        else if (i)    exp_stall = 6'b000111;
        else           exp_stall = 6'b000000;

        chk("stall", 32'(bus.stall), 32'(exp_stall));
        chk("mdu_done", 32'(bus.mdu_done), 32'(done_now));
        if (m_valid) begin
            chk("mdu_busy", 32'(bus.mdu_busy), 32'(m_busy));
            chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_scount));
            chk("mem_timeout", 32'(bus.mem_timeout), 32'(m_timeout));
        end

        if (r) begin
            m_valid = 1; m_busy = 0; m_elapsed = 0; m_waitrun = 0;
            m_timeout = 0; m_scount = 0;
        end else begin
            if (exp_stall[0] && m_scount < CNT_MAX) m_scount++;
            if (w) begin
                m_waitrun++;
                if (m_waitrun >= MEM_TIMEOUT) m_timeout = 1;
            end else begin
                m_waitrun = 0;
            end
            if (!m_busy) begin
                if (s && !w) begin
                    m_busy = 1; m_lat = d ? DIV_LAT : MUL_LAT; m_elapsed = 1;
                end
            end else if (!w) begin
                if (done_now) m_busy = 0;
                else          m_elapsed++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.id_stall_request = 0; bus.ex_mdu_start = 0; bus.ex_mdu_div = 0;
        bus.mem_ram_req = 0; bus.mem_ram_ready = 0;

        // Reset, then confirm reset state on a second reset cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0);
        idle(1);

        // Single load-use hazard
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);

        // Multiply: start once, EX drops start after acceptance
        cyc(0, 0, 1, 0, 0, 0);
        idle(5);

        // Divide with RAM wait at T+5..T+6, id request while busy
        cyc(0, 0, 1, 1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            if (k == 5 || k == 6) cyc(0, 0, 0, 0, 1, 0);
            else                  cyc(0, (k == 10), 0, 0, (k == 8), 1);
        end

        // RAM timeout: 16 waiting cycles, then ready; flag must stick
        for (int k = 0; k < MEM_TIMEOUT; k++) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        idle(3);

        // Reset in the cycle after a multiply is accepted
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(6);

        // Start held during RAM wait, then accepted; counter saturates on long stall
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 1);
        idle(4);
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0, 0);
        idle(2);

        // Randomised traffic with occasional long RAM waits and resets
        for (int k = 0; k < 3000; k++) begin
            bit r, i, s, d, q, y;
            r = ($urandom_range(0, 149) == 0);
            i = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 2) != 0);
            y = ((k / 50) % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc(r, i, s, d, q, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
